// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared CPU package: hazard/stall controller state encoding and
// load-latency limits used by the pipeline control logic.
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_HOLD = 2'd1,
    ST_MEM_WAIT  = 2'd2
  } hsc_state_t;

  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 4;

  // Remaining-bubble counter only ever holds LOAD_LAT-1 (at most 3).
  localparam int HOLD_CNT_W = $clog2(LOAD_LAT_MAX);

endpackage

// File: rtl/hazard_stall_ctrl_cmp.sv
// Load-use hazard comparator: flags when the instruction in ID reads a
// register that the load currently in EX is about to write. Register 0
// is hard-wired to zero and therefore never a real dependency.
module hazard_cmp #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic [REG_AW-1:0] rd,
  input  logic              memread,
  output logic              hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = rs_used && (rs == rd);
  assign rt_match = rt_used && (rt == rd);
  assign hazard   = memread && (rd != '0) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller. Inserts LOAD_LAT bubbles per load-use
// hazard, freezes the back end while data memory is busy (keeping the
// remaining bubble count), and flushes IF/ID on a taken branch when the
// front end is otherwise free to advance. Counts every PC-stall cycle.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] IF_ID_rs_i,
  input  logic [REG_AW-1:0] IF_ID_rt_i,
  input  logic              IF_ID_rs_used_i,
  input  logic              IF_ID_rt_used_i,
  input  logic [REG_AW-1:0] ID_EX_rd_i,
  input  logic              ID_EX_memread_i,
  input  logic              branch_taken_i,
  input  logic              mem_stall_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              id_ex_bubble_o,
  output logic              if_id_flush_o,
  output logic              pipe_freeze_o,
  output logic [CNT_W-1:0]  stall_cycles_o
);

  if (LOAD_LAT < LOAD_LAT_MIN || LOAD_LAT > LOAD_LAT_MAX) begin : g_bad_load_lat
    $error("hazard_stall_ctrl: LOAD_LAT out of range");
  end

  localparam logic [HOLD_CNT_W-1:0] HOLD_INIT = HOLD_CNT_W'(LOAD_LAT - 1);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(1);

  hsc_state_t            state;
  hsc_state_t            state_nxt;
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic [HOLD_CNT_W-1:0] hold_cnt_nxt;
  logic [CNT_W-1:0]      stall_cnt;
  logic                  hazard;
  logic                  hold_active;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hazard_cmp #(
    .REG_AW (REG_AW)
  ) u_cmp (
    .rs      (IF_ID_rs_i),
    .rt      (IF_ID_rt_i),
    .rs_used (IF_ID_rs_used_i),
    .rt_used (IF_ID_rt_used_i),
    .rd      (ID_EX_rd_i),
    .memread (ID_EX_memread_i),
    .hazard  (hazard)
  );

  // Leaving MEM_WAIT with bubbles still owed behaves exactly like LOAD_HOLD.
  assign hold_active = (state == ST_LOAD_HOLD) ||
                       ((state == ST_MEM_WAIT) && (hold_cnt != '0));

  // Output decode and next state; priority is memory stall, then load-use, then branch.
  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    id_ex_bubble_o = 1'b0;
    if_id_flush_o  = 1'b0;
    pipe_freeze_o  = 1'b0;
    state_nxt      = state;
    hold_cnt_nxt   = hold_cnt;
    if (rst_i) begin
      state_nxt    = ST_IDLE;
      hold_cnt_nxt = '0;
    end else if (mem_stall_i) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      pipe_freeze_o = 1'b1;
      state_nxt     = ST_MEM_WAIT;
    end else if (hold_active) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_bubble_o = 1'b1;
      hold_cnt_nxt   = hold_cnt - 1'b1;
      state_nxt      = (hold_cnt == HOLD_LAST) ? ST_IDLE : ST_LOAD_HOLD;
    end else if (hazard) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_bubble_o = 1'b1;
      if (LOAD_LAT > 1) begin
        hold_cnt_nxt = HOLD_INIT;
        state_nxt    = ST_LOAD_HOLD;
      end else begin
        state_nxt = ST_IDLE;
      end
    end else begin
      if_id_flush_o = branch_taken_i;
      state_nxt     = ST_IDLE;
    end
  end

  // State, remaining-bubble counter and saturating stall counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      if (!pc_write_o) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

  assign stall_cycles_o = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three instances (LOAD_LAT=1, LOAD_LAT=3,
// LOAD_LAT=1 with a 2-bit stall counter) share one directed input stream.
// Stimulus pushes hand-computed expectations into a scoreboard queue; a
// monitor pops one entry per cycle on the falling edge and compares.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic       rs_used = 1'b0, rt_used = 1'b0, memread = 1'b0;
  logic       br = 1'b0, mstall = 1'b0;

  logic        pc1, ifw1, bub1, fl1, fz1;
  logic        pc3, ifw3, bub3, fl3, fz3;
  logic        pcc, ifwc, bubc, flc, fzc;
  logic [15:0] cnt1, cnt3;
  logic [1:0]  cntc;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u_l1 (
    .clk_i(clk), .rst_i(rst), .IF_ID_rs_i(rs), .IF_ID_rt_i(rt),
    .IF_ID_rs_used_i(rs_used), .IF_ID_rt_used_i(rt_used), .ID_EX_rd_i(rd),
    .ID_EX_memread_i(memread), .branch_taken_i(br), .mem_stall_i(mstall),
    .pc_write_o(pc1), .if_id_write_o(ifw1), .id_ex_bubble_o(bub1),
    .if_id_flush_o(fl1), .pipe_freeze_o(fz1), .stall_cycles_o(cnt1));

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u_l3 (
    .clk_i(clk), .rst_i(rst), .IF_ID_rs_i(rs), .IF_ID_rt_i(rt),
    .IF_ID_rs_used_i(rs_used), .IF_ID_rt_used_i(rt_used), .ID_EX_rd_i(rd),
    .ID_EX_memread_i(memread), .branch_taken_i(br), .mem_stall_i(mstall),
    .pc_write_o(pc3), .if_id_write_o(ifw3), .id_ex_bubble_o(bub3),
    .if_id_flush_o(fl3), .pipe_freeze_o(fz3), .stall_cycles_o(cnt3));

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(2)) u_c2 (
    .clk_i(clk), .rst_i(rst), .IF_ID_rs_i(rs), .IF_ID_rt_i(rt),
    .IF_ID_rs_used_i(rs_used), .IF_ID_rt_used_i(rt_used), .ID_EX_rd_i(rd),
    .ID_EX_memread_i(memread), .branch_taken_i(br), .mem_stall_i(mstall),
    .pc_write_o(pcc), .if_id_write_o(ifwc), .id_ex_bubble_o(bubc),
    .if_id_flush_o(flc), .pipe_freeze_o(fzc), .stall_cycles_o(cntc));

  // Output patterns {pc_write, id_ex_bubble, if_id_flush, pipe_freeze}
  localparam logic [3:0] N = 4'b1000;
  localparam logic [3:0] B = 4'b0100;
  localparam logic [3:0] F = 4'b1010;
  localparam logic [3:0] Z = 4'b0001;

  typedef struct {
    string      name;
    logic [3:0] o1;
    logic [3:0] o3;
    int         c1;
    int         c3;
    int         cc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   run1 = 0, run3 = 0, runc = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One cycle of stimulus; expected counts come from a saturating tally of
  // the hand-given pc_write expectations.
  task automatic step(input string nm, input logic r,
                      input logic [4:0] s_rs, input logic s_rsu,
                      input logic [4:0] s_rt, input logic s_rtu,
                      input logic [4:0] s_rd, input logic s_mr,
                      input logic s_br, input logic s_ms,
                      input logic [3:0] e1, input logic [3:0] e3);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; rs = s_rs; rs_used = s_rsu; rt = s_rt; rt_used = s_rtu;
    rd = s_rd; memread = s_mr; br = s_br; mstall = s_ms;
    if (r) begin
      run1 = 0; run3 = 0; runc = 0;
    end
    e.name = nm; e.o1 = e1; e.o3 = e3;
    e.c1 = run1; e.c3 = run3; e.cc = runc;
    sb.push_back(e);
    if (!r && !e1[3]) begin
      if (run1 < 65535) run1++;
      if (runc < 3) runc++;
    end
    if (!r && !e3[3] && run3 < 65535) run3++;
  endtask

  task automatic quiet(input string nm, input logic [3:0] e1, input logic [3:0] e3);
    step(nm, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, e1, e3);
  endtask

  // Monitor: every cycle the combinational outputs are presented; compare
  // them with the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, " l1_out"}, int'({pc1, bub1, fl1, fz1}), int'(e.o1));
        chk({e.name, " l1_ifw"}, int'(ifw1), int'(e.o1[3]));
        chk({e.name, " l3_out"}, int'({pc3, bub3, fl3, fz3}), int'(e.o3));
        chk({e.name, " l3_ifw"}, int'(ifw3), int'(e.o3[3]));
        chk({e.name, " c2_out"}, int'({pcc, bubc, flc, fzc}), int'(e.o1));
        chk({e.name, " c2_ifw"}, int'(ifwc), int'(e.o1[3]));
        chk({e.name, " l1_cnt"}, int'(cnt1), e.c1);
        chk({e.name, " l3_cnt"}, int'(cnt3), e.c3);
        chk({e.name, " c2_cnt"}, int'(cntc), e.cc);
      end
    end
  end

  initial begin
    // Reset, including with a hazard and branch present on the inputs
    step("rst0", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, N, N);
    step("rst1", 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, N, N);
    quiet("idle", N, N);
    // Load rd=8 followed by a reader of rs=8
    step("lu_rs", 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, B, B);
    quiet("lu_h1", N, B);
    quiet("lu_h2", N, B);
    quiet("lu_end", N, N);
    // Register 0 and an unused rt never stall
    step("r0", 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, N, N);
    step("rt_unused", 1'b0, 5'd3, 1'b1, 5'd8, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, N, N);
    step("noload", 1'b0, 5'd8, 1'b1, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, N, N);
    // Hazard through rt
    step("lu_rt", 1'b0, 5'd3, 1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, B, B);
    quiet("rt_h1", N, B);
    quiet("rt_h2", N, B);
    quiet("rt_end", N, N);
    // Branch alone flushes; with a hazard the stall wins
    step("br_only", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, F, F);
    quiet("br_off", N, N);
    step("br_haz", 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, B, B);
    step("br_hold", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, F, B);
    quiet("bh_h2", N, B);
    quiet("bh_end", N, N);
    // Memory stall after the first bubble keeps the owed bubbles
    step("ms_haz", 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, B, B);
    step("ms_1", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, Z, Z);
    step("ms_2", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, Z, Z);
    quiet("ms_res1", N, B);
    quiet("ms_res2", N, B);
    quiet("ms_end", N, N);
    // Memory stall outranks a branch
    step("ms_br", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, Z, Z);
    quiet("msbr_end", N, N);
    // Reset in the middle of LOAD_HOLD
    step("rh_haz", 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, B, B);
    step("rh_rst", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, N, N);
    quiet("rh_after", N, N);
    quiet("rh_idle", N, N);
    @(posedge clk);
    @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, legal range 1..4, load-use bubble cycles.
REQ-003 SHALL have parameter CNT_W, default 16, stall-cycle counter width.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset; asynchronous, active-high.
REQ-006 IF_ID_rs_i, IF_ID_rt_i  input  REG_AW each  source registers of the instruction in ID.
REQ-007 IF_ID_rs_used_i, IF_ID_rt_used_i  input  1 each  the ID instruction actually reads rs/rt.
REQ-008 ID_EX_rd_i  input  REG_AW  destination register of the instruction in EX.
REQ-009 ID_EX_memread_i  input  1  the EX instruction is a load.
REQ-010 branch_taken_i  input  1  the branch resolved in ID is taken.
REQ-011 mem_stall_i  input  1  data memory not ready; level-held until the access completes.
REQ-012 pc_write_o  output  1  PC update enable.
REQ-013 if_id_write_o  output  1  IF/ID register write enable.
REQ-014 id_ex_bubble_o  output  1  zero ID/EX control signals (insert NOP).
REQ-015 if_id_flush_o  output  1  clear IF/ID to NOP.
REQ-016 pipe_freeze_o  output  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-017 stall_cycles_o  output  CNT_W  saturating count of cycles with pc_write_o=0.

Function
REQ-018 A hazard SHALL be raised when ID_EX_memread_i=1, ID_EX_rd_i!=0, and either (rs_used and rs==rd) or (rt_used and rt==rd).
REQ-019 Register 0 SHALL never cause a hazard.
REQ-020 FSM states SHALL be IDLE, LOAD_HOLD and MEM_WAIT.
REQ-021 In IDLE with a hazard detected: SHALL drive pc_write_o=0, if_id_write_o=0 and id_ex_bubble_o=1 in the same cycle (combinational).
REQ-022 In that IDLE case, if LOAD_LAT>1, SHALL load remaining counter = LOAD_LAT-1 and enter LOAD_HOLD.
REQ-023 In LOAD_HOLD: SHALL drive the same three outputs as REQ-021 and decrement the counter each cycle; on the cycle the counter reaches 0 (not after), return to IDLE.
REQ-024 Total bubbles per load-use hazard SHALL equal exactly LOAD_LAT.
REQ-025 mem_stall_i=1 in any state: SHALL enter/stay in MEM_WAIT with pc_write_o=0, if_id_write_o=0, pipe_freeze_o=1, id_ex_bubble_o=0 and if_id_flush_o=0.
REQ-026 During MEM_WAIT, the LOAD_HOLD counter SHALL be preserved.
REQ-027 On mem_stall_i falling: SHALL resume LOAD_HOLD if counter>0, else go to IDLE.
REQ-028 Priority SHALL be mem_stall_i > load-use stall > branch flush.
REQ-029 if_id_flush_o SHALL equal branch_taken_i only in IDLE with no hazard and mem_stall_i=0; otherwise 0 (a stalled branch re-resolves).
REQ-030 Absent stall and flush, outputs SHALL be pc_write_o=1, if_id_write_o=1, others 0.
REQ-031 stall_cycles_o SHALL increment by 1 each cycle pc_write_o=0 and saturate at 2^CNT_W-1 without wrapping.

Reset
REQ-032 rst_i SHALL immediately force state IDLE, counter 0 and stall_cycles_o=0, including mid-LOAD_HOLD or mid-MEM_WAIT.
REQ-033 During reset, control outputs SHALL be pc_write_o=1, if_id_write_o=1, id_ex_bubble_o=0, if_id_flush_o=0, pipe_freeze_o=0, independent of inputs.

Structure
REQ-034 FSM state encoding and the LOAD_LAT legal-range constants SHALL reside in the shared CPU package.
REQ-035 The hazard comparator SHALL be one sub-module, hazard_cmp (combinational match per REQ-018/019); the FSM, counters and output logic stay in the top module.

Verification
REQ-036 LOAD_LAT=1, load rd=8, next instruction rs=8 used: exactly 1 cycle with pc_write_o=0 and id_ex_bubble_o=1; stall_cycles_o=1.
REQ-037 LOAD_LAT=3, same pair: exactly 3 consecutive bubble cycles, then pc_write_o=1; stall_cycles_o=3.
REQ-038 Load rd=0 with rs=0, or rd=8 with rt=8 and rt_used=0: no stall.
REQ-039 LOAD_LAT=3, mem_stall_i pulsed 2 cycles after the first bubble: pipe_freeze_o=1 for 2 cycles, then the remaining 2 bubbles; 5 stall cycles total.
REQ-040 branch_taken_i=1 alone -> if_id_flush_o=1 for 1 cycle; branch_taken_i=1 together with a hazard -> flush 0, stall 1.
REQ-041 rst_i asserted mid-LOAD_HOLD -> outputs immediately at REQ-033 values; CNT_W=2 with 5 stalls -> stall_cycles_o holds at 3.
